// File: rtl/gemm_tile_sched.sv
// GEMM tile scheduler: walks an m x n x k GEMM in TILE-sized steps and
// issues one command per tile to a systolic engine, waiting for each tile
// to complete before offering the next.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no job; an incoming start latches the dimensions and tile 0
// ISSUE | cmd_valid high, command fields frozen until cmd_ready
// WAIT  | command accepted; waiting for the engine's tile_done pulse
// DONE  | one-cycle done pulse, then back to IDLE
module gemm_tile_sched #(
    parameter int TILE  = 8,
    parameter int DIM_W = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [DIM_W-1:0]          m,
    input  logic [DIM_W-1:0]          n,
    input  logic [DIM_W-1:0]          k,
    output logic                      cmd_valid,
    input  logic                      cmd_ready,
    output logic [DIM_W-1:0]          cmd_row0,
    output logic [DIM_W-1:0]          cmd_col0,
    output logic [DIM_W-1:0]          cmd_k0,
    output logic [$clog2(TILE):0]     cmd_rows,
    output logic [$clog2(TILE):0]     cmd_cols,
    output logic [$clog2(TILE):0]     cmd_kdepth,
    output logic                      cmd_first_k,
    output logic                      cmd_last_k,
    input  logic                      tile_done,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    output logic [31:0]               tiles_issued
);

    localparam int CW = $clog2(TILE) + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    // TILE in the three widths it is compared against
    localparam logic [DIM_W-1:0] TILE_D = DIM_W'(TILE);
    localparam logic [DIM_W:0]   TILE_W = (DIM_W+1)'(TILE);
    localparam logic [CW-1:0]    TILE_C = CW'(TILE);

    logic [1:0]       state_q, state_d;
    logic [DIM_W-1:0] m_q, n_q, k_q;
    logic [DIM_W-1:0] m_eff, n_eff, k_eff;

    logic             hs;
    logic             start_acc;
    logic             wait_done;

    logic [DIM_W:0]   k_nx, c_nx, r_nx;
    logic             k_wrap, c_wrap, r_wrap;
    logic             last_tile;

    logic [DIM_W-1:0] ld_mdim, ld_ndim, ld_kdim;
    logic [DIM_W-1:0] ld_row, ld_col, ld_k;
    logic [CW-1:0]    ld_rows, ld_cols, ld_kdepth;
    logic             ld_first, ld_last;
    logic             load_cmd;

    // Extent of a tile starting at origin: min(TILE, dim - origin), computed
    // one bit wider so large dimensions never wrap.
    function automatic logic [CW-1:0] extent(input logic [DIM_W-1:0] dim,
                                             input logic [DIM_W-1:0] origin);
        logic [DIM_W:0] rem;
        rem = {1'b0, dim} - {1'b0, origin};
        if (rem >= TILE_W)
            return TILE_C;
        else
            return rem[CW-1:0];
    endfunction

    assign hs        = cmd_valid && cmd_ready;
    assign start_acc = start && (state_q == ST_IDLE);
    assign wait_done = tile_done && (state_q == ST_WAIT);

    assign cmd_valid = (state_q == ST_ISSUE);
    assign busy      = (state_q != ST_IDLE);
    assign done      = (state_q == ST_DONE);

    // A zero dimension means one full tile
    always_comb begin
        m_eff = (m == '0) ? TILE_D : m;
        n_eff = (n == '0) ? TILE_D : n;
        k_eff = (k == '0) ? TILE_D : k;
    end

    // Successor of the tile currently held in the command registers
    always_comb begin
        k_nx      = {1'b0, cmd_k0}   + TILE_W;
        c_nx      = {1'b0, cmd_col0} + TILE_W;
        r_nx      = {1'b0, cmd_row0} + TILE_W;
        k_wrap    = (k_nx >= {1'b0, k_q});
        c_wrap    = (c_nx >= {1'b0, n_q});
        r_wrap    = (r_nx >= {1'b0, m_q});
        last_tile = k_wrap && c_wrap && r_wrap;
    end

    // Values to load into the command registers: tile 0 of the new job on
    // start, otherwise the successor tile (K innermost, then col, then row)
    always_comb begin
        if (state_q == ST_IDLE) begin
            ld_mdim = m_eff;
            ld_ndim = n_eff;
            ld_kdim = k_eff;
            ld_row  = '0;
            ld_col  = '0;
            ld_k    = '0;
        end else begin
            ld_mdim = m_q;
            ld_ndim = n_q;
            ld_kdim = k_q;
            ld_k    = k_wrap ? '0 : k_nx[DIM_W-1:0];
            if (!k_wrap)
                ld_col = cmd_col0;
            else if (c_wrap)
                ld_col = '0;
            else
                ld_col = c_nx[DIM_W-1:0];
            ld_row  = (k_wrap && c_wrap) ? r_nx[DIM_W-1:0] : cmd_row0;
        end
        ld_rows   = extent(ld_mdim, ld_row);
        ld_cols   = extent(ld_ndim, ld_col);
        ld_kdepth = extent(ld_kdim, ld_k);
        ld_first  = (ld_k == '0);
        ld_last   = (({1'b0, ld_k} + TILE_W) >= {1'b0, ld_kdim});
        load_cmd  = start_acc || (wait_done && !last_tile);
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (start)     state_d = ST_ISSUE;
            ST_ISSUE: if (hs)        state_d = ST_WAIT;
            ST_WAIT:  if (tile_done) state_d = last_tile ? ST_DONE : ST_ISSUE;
            ST_DONE:                 state_d = ST_IDLE;
            default:                 state_d = ST_IDLE;
        endcase
    end

    // State, job registers, command registers and status
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            m_q          <= '0;
            n_q          <= '0;
            k_q          <= '0;
            cmd_row0     <= '0;
            cmd_col0     <= '0;
            cmd_k0       <= '0;
            cmd_rows     <= '0;
            cmd_cols     <= '0;
            cmd_kdepth   <= '0;
            cmd_first_k  <= 1'b0;
            cmd_last_k   <= 1'b0;
            err          <= 1'b0;
            tiles_issued <= '0;
        end else begin
            state_q <= state_d;

            if (start_acc) begin
                m_q          <= m_eff;
                n_q          <= n_eff;
                k_q          <= k_eff;
                tiles_issued <= '0;
                // a stray tile_done in the very launch cycle still counts
                err          <= tile_done;
            end else if (tile_done && (state_q != ST_WAIT)) begin
                err <= 1'b1;
            end

            if (hs)
                tiles_issued <= tiles_issued + 32'd1;

            if (load_cmd) begin
                cmd_row0    <= ld_row;
                cmd_col0    <= ld_col;
                cmd_k0      <= ld_k;
                cmd_rows    <= ld_rows;
                cmd_cols    <= ld_cols;
                cmd_kdepth  <= ld_kdepth;
                cmd_first_k <= ld_first;
                cmd_last_k  <= ld_last;
            end
        end
    end

endmodule

// File: tb/tb_gemm_tile_sched.sv
// Directed bench for gemm_tile_sched with TILE=8, DIM_W=16.
module tb_gemm_tile_sched;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] m, n, k;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [15:0] cmd_row0, cmd_col0, cmd_k0;
    logic [3:0]  cmd_rows, cmd_cols, cmd_kdepth;
    logic        cmd_first_k, cmd_last_k;
    logic        tile_done;
    logic        busy, done, err;
    logic [31:0] tiles_issued;

    int passed = 0;
    int total  = 0;

    gemm_tile_sched #(.TILE(8), .DIM_W(16)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .m            (m),
        .n            (n),
        .k            (k),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_row0     (cmd_row0),
        .cmd_col0     (cmd_col0),
        .cmd_k0       (cmd_k0),
        .cmd_rows     (cmd_rows),
        .cmd_cols     (cmd_cols),
        .cmd_kdepth   (cmd_kdepth),
        .cmd_first_k  (cmd_first_k),
        .cmd_last_k   (cmd_last_k),
        .tile_done    (tile_done),
        .busy         (busy),
        .done         (done),
        .err          (err),
        .tiles_issued (tiles_issued)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    endtask

    // Expect a command offer with the given fields, accept it, then complete it
    task automatic issue_expect(input int r0, input int c0, input int k0,
                                input int rows, input int cols, input int kd,
                                input int fk, input int lk, input int cnt);
        chk("cmd_valid", 32'(cmd_valid), 32'd1);
        chk("row0",      32'(cmd_row0),  32'(r0));
        chk("col0",      32'(cmd_col0),  32'(c0));
        chk("k0",        32'(cmd_k0),    32'(k0));
        chk("rows",      32'(cmd_rows),  32'(rows));
        chk("cols",      32'(cmd_cols),  32'(cols));
        chk("kdepth",    32'(cmd_kdepth), 32'(kd));
        chk("first_k",   32'(cmd_first_k), 32'(fk));
        chk("last_k",    32'(cmd_last_k),  32'(lk));
        cmd_ready = 1'b1;
        tick();
        chk("valid_low_in_wait", 32'(cmd_valid), 32'd0);
        chk("tiles_issued",      tiles_issued,   32'(cnt));
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
    endtask

    task automatic launch(input int mm, input int nn, input int kk);
        m = 16'(mm);
        n = 16'(nn);
        k = 16'(kk);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic expect_done(input int cnt);
        chk("done_pulse",     32'(done), 32'd1);
        chk("done_busy",      32'(busy), 32'd1);
        chk("done_tiles",     tiles_issued, 32'(cnt));
        tick();
        chk("done_cleared",   32'(done), 32'd0);
        chk("idle_busy",      32'(busy), 32'd0);
    endtask

    // m=20, n=8, k=16: rows 0,8,16 with two K steps each
    task automatic run_20_8_16();
        launch(20, 8, 16);
        issue_expect( 0, 0, 0, 8, 8, 8, 1, 0, 1);
        issue_expect( 0, 0, 8, 8, 8, 8, 0, 1, 2);
        issue_expect( 8, 0, 0, 8, 8, 8, 1, 0, 3);
        issue_expect( 8, 0, 8, 8, 8, 8, 0, 1, 4);
        issue_expect(16, 0, 0, 4, 8, 8, 1, 0, 5);
        issue_expect(16, 0, 8, 4, 8, 8, 0, 1, 6);
        expect_done(6);
    endtask

    initial begin
        rst       = 1'b1;
        start     = 1'b0;
        m         = '0;
        n         = '0;
        k         = '0;
        cmd_ready = 1'b1;
        tile_done = 1'b0;
        tick();
        tick();
        rst = 1'b0;

        // reset values
        chk("rst_cmd_valid", 32'(cmd_valid), 32'd0);
        chk("rst_busy",      32'(busy),      32'd0);
        chk("rst_done",      32'(done),      32'd0);
        chk("rst_err",       32'(err),       32'd0);
        chk("rst_tiles",     tiles_issued,   32'd0);
        chk("rst_rows",      32'(cmd_rows),  32'd0);
        chk("rst_last_k",    32'(cmd_last_k), 32'd0);

        // single-tile job
        launch(8, 8, 8);
        chk("single_busy", 32'(busy), 32'd1);
        issue_expect(0, 0, 0, 8, 8, 8, 1, 1, 1);
        expect_done(1);

        // zero dimensions mean TILE
        launch(0, 0, 0);
        issue_expect(0, 0, 0, 8, 8, 8, 1, 1, 1);
        expect_done(1);

        // six-tile job, K innermost then row
        run_20_8_16();

        // backpressure: first command held for five cycles
        cmd_ready = 1'b0;
        launch(12, 20, 8);
        for (int i = 0; i < 5; i++) begin
            chk("stall_valid", 32'(cmd_valid),  32'd1);
            chk("stall_cols",  32'(cmd_cols),   32'd8);
            chk("stall_k0",    32'(cmd_k0),     32'd0);
            chk("stall_tiles", tiles_issued,    32'd0);
            tick();
        end
        issue_expect(0,  0, 0, 8, 8, 8, 1, 1, 1);
        issue_expect(0,  8, 0, 8, 8, 8, 1, 1, 2);
        issue_expect(0, 16, 0, 8, 4, 8, 1, 1, 3);
        issue_expect(8,  0, 0, 4, 8, 8, 1, 1, 4);
        issue_expect(8,  8, 0, 4, 8, 8, 1, 1, 5);
        issue_expect(8, 16, 0, 4, 4, 8, 1, 1, 6);
        expect_done(6);

        // start during WAIT is ignored
        launch(16, 8, 8);
        chk("w_valid", 32'(cmd_valid), 32'd1);
        tick();
        chk("w_in_wait", 32'(cmd_valid), 32'd0);
        m = 16'd40;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("w_still_wait",  32'(cmd_valid),  32'd0);
        chk("w_tiles_same",  tiles_issued,    32'd1);
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        issue_expect(8, 0, 0, 8, 8, 8, 1, 1, 2);
        expect_done(2);
        chk("w_no_err", 32'(err), 32'd0);

        // stray tile_done in IDLE sets a sticky err
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        chk("idle_td_err",  32'(err),  32'd1);
        chk("idle_td_busy", 32'(busy), 32'd0);
        tick();
        chk("err_held", 32'(err), 32'd1);
        launch(8, 8, 8);
        chk("err_cleared", 32'(err), 32'd0);
        // tile_done coincident with the handshake is also out of state
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        chk("hs_td_err",   32'(err),       32'd1);
        chk("hs_td_wait",  32'(cmd_valid), 32'd0);
        chk("hs_td_busy",  32'(busy),      32'd1);
        tile_done = 1'b1;
        tick();
        tile_done = 1'b0;
        expect_done(1);
        chk("hs_td_err_held", 32'(err), 32'd1);

        // reset in the middle of a six-tile job
        launch(20, 8, 16);
        tick();
        chk("pre_rst_tiles", tiles_issued, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_busy",  32'(busy),      32'd0);
        chk("mid_rst_valid", 32'(cmd_valid), 32'd0);
        chk("mid_rst_tiles", tiles_issued,   32'd0);
        chk("mid_rst_row0",  32'(cmd_row0),  32'd0);
        tick();
        chk("post_rst_valid", 32'(cmd_valid), 32'd0);
        run_20_8_16();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
